// File: rtl/out_stream_serializer_if.sv
// Stream-side and pin-side signals of the output serializer, bundled for port use.
// master = kernel/board side, slave = serializer.
interface out_stream_serializer_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 4
);
  logic [NUM_CH*DATA_W-1:0] ch_din;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH-1:0]        ch_full_n;
  logic [OUT_W-1:0]         data_out;
  logic                     data_valid;
  logic                     probe_out;

  modport master (
    output ch_din, ch_write,
    input  ch_full_n, data_out, data_valid, probe_out
  );

  modport slave (
    input  ch_din, ch_write,
    output ch_full_n, data_out, data_valid, probe_out
  );
endinterface

// File: rtl/out_stream_serializer.sv
// Per-channel FIFOs feeding a frame-level round-robin serializer: header nibble, then payload LSB first.
// Define SERIALIZER_CHECKSUM_EN to append an XOR-of-payload checksum beat to every frame.
module out_stream_serializer #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int OUT_W      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  out_stream_serializer_if.slave   bus
);

  localparam int BEATS  = DATA_W / OUT_W;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
`ifdef SERIALIZER_CHECKSUM_EN
    S_CSUM,
`endif
    S_PAYLOAD
  } state_t;

  logic [NUM_CH-1:0] w_nonempty;
  logic [NUM_CH-1:0] w_full_n;
  logic [NUM_CH-1:0] w_pop;
  logic [DATA_W-1:0] w_head [NUM_CH];

  // Channel buffers
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;

    assign w_push = bus.ch_write[gi] && (r_count != FULL_CNT);

    always_ff @(posedge ap_clk) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.ch_din[gi*DATA_W +: DATA_W];
      end
    end

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[gi]) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop[gi]) begin
          r_count <= r_count + 1'b1;
        end else if (!w_push && w_pop[gi]) begin
          r_count <= r_count - 1'b1;
        end
      end
    end

    assign w_head[gi]     = r_mem[r_rd_ptr];
    assign w_nonempty[gi] = (r_count != '0);
    assign w_full_n[gi]   = (r_count != FULL_CNT);
  end

  state_t            r_state, w_state_next;
  logic [CH_W-1:0]   r_rr_ptr, w_rr_next;
  logic [CH_W-1:0]   r_ch_id, w_ch_id_next;
  logic [DATA_W-1:0] r_sr, w_sr_next;
  logic [BEAT_W-1:0] r_beat, w_beat_next;
  logic [OUT_W-1:0]  r_csum, w_csum_next;
  logic              r_probe;
  logic              w_grant_en;
  logic              w_grant;
  logic [CH_W-1:0]   w_grant_idx;
  logic [OUT_W-1:0]  w_data_out;
  logic              w_data_valid;

  // First non-empty channel after the last one served
  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = r_rr_ptr;
    for (int i = 1; i <= NUM_CH; i++) begin
      int idx;
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!w_grant && w_nonempty[CH_W'(idx)]) begin
        w_grant     = 1'b1;
        w_grant_idx = CH_W'(idx);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr_ptr;
    w_ch_id_next = r_ch_id;
    w_sr_next    = r_sr;
    w_beat_next  = r_beat;
    w_csum_next  = r_csum;
    w_data_out   = '0;
    w_data_valid = 1'b0;
    w_grant_en   = 1'b0;
    w_pop        = '0;

    case (r_state)
      S_IDLE: begin
        w_grant_en = 1'b1;
      end
      S_HDR: begin
        w_data_out   = {1'b1, (OUT_W-1)'(r_ch_id)};
        w_data_valid = 1'b1;
        w_beat_next  = '0;
        w_state_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_data_out   = r_sr[OUT_W-1:0];
        w_data_valid = 1'b1;
        w_sr_next    = r_sr >> OUT_W;
        w_beat_next  = r_beat + 1'b1;
        w_csum_next  = r_csum ^ r_sr[OUT_W-1:0];
        if (r_beat == LAST_BEAT) begin
`ifdef SERIALIZER_CHECKSUM_EN
          w_state_next = S_CSUM;
`else
          w_grant_en   = 1'b1;
          w_state_next = S_IDLE;
`endif
        end
      end
`ifdef SERIALIZER_CHECKSUM_EN
      S_CSUM: begin
        w_data_out   = r_csum;
        w_data_valid = 1'b1;
        w_grant_en   = 1'b1;
        w_state_next = S_IDLE;
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // A grant overrides the fall-back to IDLE so frames run back to back
    if (w_grant_en && w_grant) begin
      w_pop[w_grant_idx] = 1'b1;
      w_state_next       = S_HDR;
      w_rr_next          = w_grant_idx;
      w_ch_id_next       = w_grant_idx;
      w_sr_next          = w_head[w_grant_idx];
      w_csum_next        = '0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= CH_W'(NUM_CH - 1);
      r_ch_id  <= '0;
      r_sr     <= '0;
      r_beat   <= '0;
      r_csum   <= '0;
      r_probe  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_next;
      r_ch_id  <= w_ch_id_next;
      r_sr     <= w_sr_next;
      r_beat   <= w_beat_next;
      r_csum   <= w_csum_next;
      if (w_data_valid) r_probe <= r_probe ^ (^w_data_out);
    end
  end

  assign bus.ch_full_n  = w_full_n;
  assign bus.data_out   = w_data_out;
  assign bus.data_valid = w_data_valid;
  assign bus.probe_out  = r_probe;

endmodule

// File: tb/tb_out_stream_serializer.sv
// Scoreboard bench for out_stream_serializer: directed scenarios followed by random traffic,
// checked against a queue-based frame scheduling model.
module tb_out_stream_serializer;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 32;
  localparam int OUT_W      = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int BEATS      = DATA_W / OUT_W;
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int FL = BEATS + 2;
`else
  localparam int FL = BEATS + 1;
`endif

  typedef struct {
    int unsigned      cyc;
    logic [OUT_W-1:0] data;
  } beat_t;

  logic ap_clk;
  logic ap_rst;

  out_stream_serializer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  out_stream_serializer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Reference model state
  logic [DATA_W-1:0] mq [NUM_CH][$];
  beat_t             sb [$];
  int unsigned       cyc = 0;
  int                busy = 0;
  int                rr = NUM_CH - 1;

  // Bench-side requests handed to the monitor
  int req_rst_chk = 0;
  int timeouts    = 0;

  int n_checks = 0;
  int n_fails  = 0;

  // Frame scheduler: one grant per free output slot, round-robin over non-empty queues
  initial begin
    forever begin
      logic [NUM_CH-1:0] acc;
      logic [DATA_W-1:0] word;
      logic [OUT_W-1:0]  nib;
      logic [OUT_W-1:0]  csum;
      int                g;
      @(posedge ap_clk);
      cyc = cyc + 1;
      if (ap_rst) begin
        for (int k = 0; k < NUM_CH; k++) mq[k].delete();
        sb.delete();
        busy = 0;
        rr   = NUM_CH - 1;
      end else begin
        if (busy > 0) busy = busy - 1;
        for (int k = 0; k < NUM_CH; k++)
          acc[k] = bus.ch_write[k] && (mq[k].size() < FIFO_DEPTH);
        if (busy == 0) begin
          g = -1;
          for (int i = 1; i <= NUM_CH; i++) begin
            int k;
            k = (rr + i) % NUM_CH;
            if (g < 0 && mq[k].size() > 0) g = k;
          end
          if (g >= 0) begin
            word = mq[g].pop_front();
            rr   = g;
            busy = FL;
            sb.push_back('{cyc: cyc, data: OUT_W'((1 << (OUT_W - 1)) + g)});
            csum = '0;
            for (int i = 0; i < BEATS; i++) begin
              nib  = OUT_W'((word >> (OUT_W * i)) & ((1 << OUT_W) - 1));
              csum = csum ^ nib;
              sb.push_back('{cyc: cyc + 1 + i, data: nib});
            end
`ifdef SERIALIZER_CHECKSUM_EN
            sb.push_back('{cyc: cyc + 1 + BEATS, data: csum});
`endif
          end
        end
        for (int k = 0; k < NUM_CH; k++)
          if (acc[k]) mq[k].push_back(bus.ch_din[k*DATA_W +: DATA_W]);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: samples the DUT mid-cycle and consumes the scoreboard
  initial begin
    logic exp_probe;
    int   seen_rst_chk;
    int   seen_timeouts;
    exp_probe     = 1'b0;
    seen_rst_chk  = 0;
    seen_timeouts = 0;
    forever begin
      logic  exp_v;
      beat_t b;
      logic  upd;
      @(negedge ap_clk);
      if (cyc == 0) continue;
      upd = 1'b0;
      for (int k = 0; k < NUM_CH; k++)
        chk($sformatf("full_n[%0d]", k), 64'(bus.ch_full_n[k]), 64'(mq[k].size() != FIFO_DEPTH));
      chk("probe_out", 64'(bus.probe_out), 64'(exp_probe));
      exp_v = (sb.size() > 0) && (sb[0].cyc <= cyc);
      chk("data_valid", 64'(bus.data_valid), 64'(exp_v));
      if (exp_v) begin
        b = sb.pop_front();
        if (bus.data_valid) chk("data_out", 64'(bus.data_out), 64'(b.data));
        upd = 1'b1;
      end
      if (req_rst_chk != seen_rst_chk) begin
        seen_rst_chk = req_rst_chk;
        chk("rst_data_out", 64'(bus.data_out), 64'(0));
        chk("rst_data_valid", 64'(bus.data_valid), 64'(0));
        chk("rst_full_n", 64'(bus.ch_full_n), 64'({NUM_CH{1'b1}}));
        chk("rst_probe", 64'(bus.probe_out), 64'(0));
      end
      if (timeouts != seen_timeouts) begin
        seen_timeouts = timeouts;
        chk("drain_timeout", 64'(sb.size()), 64'(0));
      end
      if (ap_rst) exp_probe = 1'b0;
      else if (upd) exp_probe = exp_probe ^ (^b.data);
    end
  end

  task automatic step(input logic [NUM_CH-1:0] wr, input logic [NUM_CH*DATA_W-1:0] din);
    bus.ch_write = wr;
    bus.ch_din   = din;
    @(posedge ap_clk);
    #1;
    bus.ch_write = '0;
  endtask

  task automatic reset_pulse(input int n);
    ap_rst = 1'b1;
    repeat (n) step('0, '0);
    req_rst_chk = req_rst_chk + 1;
    ap_rst = 1'b0;
  endtask

  task automatic drain();
    int  n;
    logic idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < 3000) begin
      idle = (sb.size() == 0) && (busy == 0);
      for (int k = 0; k < NUM_CH; k++) if (mq[k].size() != 0) idle = 1'b0;
      if (!idle) begin
        step('0, '0);
        n = n + 1;
      end
    end
    if (!idle) timeouts = timeouts + 1;
    step('0, '0);
    step('0, '0);
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] put(input int k, input logic [DATA_W-1:0] w);
    logic [NUM_CH*DATA_W-1:0] v;
    v = '0;
    v[k*DATA_W +: DATA_W] = w;
    return v;
  endfunction

  initial begin
    logic [NUM_CH-1:0]        wr;
    logic [NUM_CH*DATA_W-1:0] din;
    ap_rst       = 1'b1;
    bus.ch_write = '0;
    bus.ch_din   = '0;
    #1;
    reset_pulse(3);

    // Single word on ch0
    step('0, '0);
    step(4'b0001, put(0, 32'h87654321));
    drain();

    // ch1 and ch3 in the same cycle
    step(4'b1010, put(1, 32'hAAAA5555) | put(3, 32'h0000FFFF));
    drain();

    // ch2 overflow while a ch0 frame is in flight
    step(4'b0001, put(0, 32'h13572468));
    for (int i = 0; i < 9; i++) step(4'b0100, put(2, 32'hC0DE0000 + i));
    drain();

    // Fairness with all channels loaded
    reset_pulse(1);
    for (int r = 0; r < 2; r++) begin
      din = '0;
      for (int k = 0; k < NUM_CH; k++) din[k*DATA_W +: DATA_W] = 32'h10000000 * (k + 1) + r;
      step('1, din);
    end
    drain();

    // Reset during payload beat 3
    step(4'b0001, put(0, 32'h87654321));
    repeat (5) step('0, '0);
    reset_pulse(1);
    drain();

    // Random traffic with one reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        reset_pulse(1);
      end else begin
        wr = '0;
        din = '0;
        for (int k = 0; k < NUM_CH; k++) begin
          wr[k] = ($urandom_range(0, 99) < 30);
          din[k*DATA_W +: DATA_W] = $urandom;
        end
        step(wr, din);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
